// File: rtl/onehot_grant_decoder_pkg.sv
// onehot_grant_decoder_pkg
//   Shared constants for the one-hot grant decoder:
//   - completion status encodings reported on done_status
//   - IDLE/ACTIVE state constants
//   - helper that sizes the grant timeout counter
package onehot_grant_decoder_pkg;

  // done_status encodings
  localparam logic [1:0] ST_ACK     = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_RANGE   = 2'b10;

  // FSM state constants
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  // Bits needed to count 0..timeout; at least one bit even when disabled.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    if (timeout == 32'd0) begin
      return 32'd1;
    end else begin
      return $clog2(timeout + 32'd1);
    end
  endfunction

endpackage

// File: rtl/onehot_grant_decoder_grant_timeout_counter.sv
// grant_timeout_counter
//   Clear/enable saturating up-counter with a terminal-count flag.
//   Ports:
//     clk   - clock, rising edge
//     rst_n - asynchronous active-low reset (count -> 0)
//     clr   - synchronous clear, has priority over en
//     en    - count enable; the count holds at all-ones instead of wrapping
//     tc    - high while the count equals the TC parameter
module grant_timeout_counter
  import onehot_grant_decoder_pkg::*;
#(
  parameter int unsigned CW = 8,
  parameter int unsigned TC = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] TC_VAL  = CW'(TC);

  logic [CW-1:0] count_r;

  // Saturating counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CW{1'b0}};
    end else if (clr) begin
      count_r <= {CW{1'b0}};
    end else if (en && (count_r != CNT_MAX)) begin
      count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == TC_VAL);

endmodule

// File: rtl/onehot_grant_decoder.sv
// onehot_grant_decoder
//   Takes a binary index on a valid/ready stream and drives the matching
//   one-hot grant until the target acknowledges or a timeout expires, then
//   emits a single-cycle completion pulse. A one-deep pending buffer lets the
//   next request be taken while a grant is active.
//   Ports:
//     clk, rst_n        - clock (rising edge), asynchronous active-low reset
//     input_encoded     - requested grant index (IW bits)
//     input_valid/ready - request handshake; ready = pending buffer empty
//     output_unencoded  - one-hot grant, zero when idle
//     output_valid      - grant active
//     output_ack        - per-target acknowledge; only the granted bit counts
//     done_valid        - single-cycle completion pulse
//     done_encoded      - completed index (held between pulses)
//     done_status       - ST_ACK / ST_TIMEOUT / ST_RANGE (held between pulses)
module onehot_grant_decoder
  import onehot_grant_decoder_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned IW      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IW-1:0]    input_encoded,
  input  logic             input_valid,
  output logic             input_ready,
  output logic [WIDTH-1:0] output_unencoded,
  output logic             output_valid,
  input  logic [WIDTH-1:0] output_ack,
  output logic             done_valid,
  output logic [IW-1:0]    done_encoded,
  output logic [1:0]       done_status
);

  localparam int unsigned    CW        = cnt_width(TIMEOUT);
  localparam int unsigned    TC        = (TIMEOUT == 32'd0) ? 32'd0 : (TIMEOUT - 32'd1);
  localparam bit             TO_EN     = (TIMEOUT != 32'd0);
  localparam logic [WIDTH-1:0] GRANT_LSB = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic in_range(input logic [IW-1:0] idx);
    return ({{(32-IW){1'b0}}, idx} < 32'(WIDTH));
  endfunction

  logic [0:0]       state_r,        state_s;
  logic [WIDTH-1:0] grant_r,        grant_s;
  logic [IW-1:0]    active_idx_r,   active_idx_s;
  logic             pend_valid_r,   pend_valid_s;
  logic [IW-1:0]    pend_idx_r,     pend_idx_s;
  logic             done_valid_r,   done_valid_s;
  logic [IW-1:0]    done_encoded_r, done_encoded_s;
  logic [1:0]       done_status_r,  done_status_s;

  logic accept_s;
  logic ack_hit_s;
  logic cnt_clr_s;
  logic cnt_en_s;
  logic cnt_tc_s;

  // Ready depends only on the pending register, never on input_valid.
  assign accept_s  = input_valid & ~pend_valid_r;
  // Grant is one-hot, so masking the ack with it honours only the active bit.
  assign ack_hit_s = |(output_ack & grant_r);

  // Cycles-in-grant counter; terminal count marks the last allowed cycle
  grant_timeout_counter #(
    .CW (CW),
    .TC (TC)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr_s),
    .en    (cnt_en_s),
    .tc    (cnt_tc_s)
  );

  // Next-state logic for grant, pending buffer and completion reporting
  always_comb begin
    state_s        = state_r;
    grant_s        = grant_r;
    active_idx_s   = active_idx_r;
    pend_valid_s   = pend_valid_r;
    pend_idx_s     = pend_idx_r;
    done_valid_s   = 1'b0;
    done_encoded_s = done_encoded_r;
    done_status_s  = done_status_r;
    cnt_clr_s      = 1'b0;
    cnt_en_s       = 1'b0;

    case (state_r)
      S_IDLE: begin
        // A pending entry in IDLE was captured on the completion edge; it is
        // served before any new request (input_ready is low meanwhile).
        if (pend_valid_r) begin
          pend_valid_s = 1'b0;
          if (in_range(pend_idx_r)) begin
            state_s      = S_ACTIVE;
            grant_s      = GRANT_LSB << pend_idx_r;
            active_idx_s = pend_idx_r;
            cnt_clr_s    = 1'b1;
          end else begin
            done_valid_s   = 1'b1;
            done_encoded_s = pend_idx_r;
            done_status_s  = ST_RANGE;
          end
        end else if (accept_s) begin
          if (in_range(input_encoded)) begin
            state_s      = S_ACTIVE;
            grant_s      = GRANT_LSB << input_encoded;
            active_idx_s = input_encoded;
            cnt_clr_s    = 1'b1;
          end else begin
            done_valid_s   = 1'b1;
            done_encoded_s = input_encoded;
            done_status_s  = ST_RANGE;
          end
        end else begin
          state_s = S_IDLE;
        end
      end

      S_ACTIVE: begin
        cnt_en_s = 1'b1;
        if (ack_hit_s || (TO_EN && cnt_tc_s)) begin
          done_valid_s   = 1'b1;
          done_encoded_s = active_idx_r;
          done_status_s  = ack_hit_s ? ST_ACK : ST_TIMEOUT;
          state_s        = S_IDLE;
          grant_s        = {WIDTH{1'b0}};
          if (pend_valid_r) begin
            // In-range pending chains straight into the next grant; an
            // out-of-range one stays buffered so IDLE reports it next cycle.
            if (in_range(pend_idx_r)) begin
              state_s      = S_ACTIVE;
              grant_s      = GRANT_LSB << pend_idx_r;
              active_idx_s = pend_idx_r;
              pend_valid_s = 1'b0;
              cnt_clr_s    = 1'b1;
            end else begin
              pend_valid_s = 1'b1;
            end
          end else if (accept_s) begin
            pend_valid_s = 1'b1;
            pend_idx_s   = input_encoded;
          end else begin
            pend_valid_s = 1'b0;
          end
        end else if (accept_s) begin
          pend_valid_s = 1'b1;
          pend_idx_s   = input_encoded;
        end else begin
          state_s = S_ACTIVE;
        end
      end

      default: begin
        state_s      = S_IDLE;
        grant_s      = {WIDTH{1'b0}};
        pend_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= S_IDLE;
      grant_r        <= {WIDTH{1'b0}};
      active_idx_r   <= {IW{1'b0}};
      pend_valid_r   <= 1'b0;
      pend_idx_r     <= {IW{1'b0}};
      done_valid_r   <= 1'b0;
      done_encoded_r <= {IW{1'b0}};
      done_status_r  <= 2'b00;
    end else begin
      state_r        <= state_s;
      grant_r        <= grant_s;
      active_idx_r   <= active_idx_s;
      pend_valid_r   <= pend_valid_s;
      pend_idx_r     <= pend_idx_s;
      done_valid_r   <= done_valid_s;
      done_encoded_r <= done_encoded_s;
      done_status_r  <= done_status_s;
    end
  end

  assign input_ready      = ~pend_valid_r;
  assign output_unencoded = grant_r;
  assign output_valid     = |grant_r;
  assign done_valid       = done_valid_r;
  assign done_encoded     = done_encoded_r;
  assign done_status      = done_status_r;

endmodule

// File: tb/tb_onehot_grant_decoder.sv
// Directed bench: instance a is WIDTH=4/TIMEOUT=8, instance b is
// WIDTH=5/TIMEOUT=0 (non power-of-two width, timeout disabled).
module tb_onehot_grant_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [1:0] a_enc = 2'd0;
  logic       a_valid = 1'b0;
  logic       a_ready;
  logic [3:0] a_grant;
  logic       a_ovalid;
  logic [3:0] a_ack = 4'd0;
  logic       a_dv;
  logic [1:0] a_de;
  logic [1:0] a_ds;

  logic [2:0] b_enc = 3'd0;
  logic       b_valid = 1'b0;
  logic       b_ready;
  logic [4:0] b_grant;
  logic       b_ovalid;
  logic [4:0] b_ack = 5'd0;
  logic       b_dv;
  logic [2:0] b_de;
  logic [1:0] b_ds;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  onehot_grant_decoder #(.WIDTH(4), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .input_encoded(a_enc), .input_valid(a_valid), .input_ready(a_ready),
    .output_unencoded(a_grant), .output_valid(a_ovalid), .output_ack(a_ack),
    .done_valid(a_dv), .done_encoded(a_de), .done_status(a_ds)
  );

  onehot_grant_decoder #(.WIDTH(5), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .input_encoded(b_enc), .input_valid(b_valid), .input_ready(b_ready),
    .output_unencoded(b_grant), .output_valid(b_ovalid), .output_ack(b_ack),
    .done_valid(b_dv), .done_encoded(b_de), .done_status(b_ds)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [3:0] g, input logic rdy, input logic dv);
    chk({tag, ".grant"}, 32'(a_grant), 32'(g));
    chk({tag, ".ovalid"}, 32'(a_ovalid), 32'(|g));
    chk({tag, ".ready"}, 32'(a_ready), 32'(rdy));
    chk({tag, ".dv"}, 32'(a_dv), 32'(dv));
  endtask

  task automatic chk_a_done(input string tag, input logic [1:0] de, input logic [1:0] ds);
    chk({tag, ".de"}, 32'(a_de), 32'(de));
    chk({tag, ".ds"}, 32'(a_ds), 32'(ds));
  endtask

  task automatic chk_b(input string tag, input logic [4:0] g, input logic rdy, input logic dv,
                       input logic [2:0] de, input logic [1:0] ds);
    chk({tag, ".grant"}, 32'(b_grant), 32'(g));
    chk({tag, ".ovalid"}, 32'(b_ovalid), 32'(|g));
    chk({tag, ".ready"}, 32'(b_ready), 32'(rdy));
    chk({tag, ".dv"}, 32'(b_dv), 32'(dv));
    chk({tag, ".de"}, 32'(b_de), 32'(de));
    chk({tag, ".ds"}, 32'(b_ds), 32'(ds));
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk_a("reset", 4'b0000, 1'b1, 1'b0);
    chk_a_done("reset", 2'd0, 2'b00);
    chk_b("reset", 5'b00000, 1'b1, 1'b0, 3'd0, 2'b00);
    rst_n = 1'b1;
    tick();

    // 1: idx 2, ack during the 3rd grant cycle
    a_enc = 2'd2; a_valid = 1'b1;
    tick();
    chk_a("t1.c1", 4'b0100, 1'b1, 1'b0);
    a_valid = 1'b0;
    tick();
    chk_a("t1.c2", 4'b0100, 1'b1, 1'b0);
    tick();
    chk_a("t1.c3", 4'b0100, 1'b1, 1'b0);
    a_ack = 4'b0100;
    tick();
    chk_a("t1.done", 4'b0000, 1'b1, 1'b1);
    chk_a_done("t1.done", 2'd2, 2'b00);
    a_ack = 4'b0000;
    tick();
    chk_a("t1.after", 4'b0000, 1'b1, 1'b0);
    chk_a_done("t1.hold", 2'd2, 2'b00);

    // 2: idx 1, no ack, timeout after exactly 8 grant cycles
    a_enc = 2'd1; a_valid = 1'b1;
    tick();
    chk_a("t2.c1", 4'b0010, 1'b1, 1'b0);
    a_valid = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk_a($sformatf("t2.c%0d", k), 4'b0010, 1'b1, 1'b0);
    end
    tick();
    chk_a("t2.done", 4'b0000, 1'b1, 1'b1);
    chk_a_done("t2.done", 2'd1, 2'b01);
    tick();
    chk_a("t2.after", 4'b0000, 1'b1, 1'b0);

    // 3: idx 0 active, idx 3 pending, ack 0 -> direct chain to idx 3
    a_enc = 2'd0; a_valid = 1'b1;
    tick();
    chk_a("t3.g0", 4'b0001, 1'b1, 1'b0);
    a_enc = 2'd3;
    tick();
    chk_a("t3.pend", 4'b0001, 1'b0, 1'b0);
    a_valid = 1'b0; a_ack = 4'b0001;
    tick();
    chk_a("t3.chain", 4'b1000, 1'b1, 1'b1);
    chk_a_done("t3.chain", 2'd0, 2'b00);
    a_ack = 4'b0000;
    tick();
    chk_a("t3.g3", 4'b1000, 1'b1, 1'b0);
    a_ack = 4'b1000;
    tick();
    chk_a("t3.done3", 4'b0000, 1'b1, 1'b1);
    chk_a_done("t3.done3", 2'd3, 2'b00);
    a_ack = 4'b0000;

    // Request accepted on the completion edge with empty pending buffer
    a_enc = 2'd0; a_valid = 1'b1;
    tick();
    chk_a("t3b.g0", 4'b0001, 1'b1, 1'b0);
    a_enc = 2'd2; a_ack = 4'b0001;
    tick();
    chk_a("t3b.done", 4'b0000, 1'b0, 1'b1);
    chk_a_done("t3b.done", 2'd0, 2'b00);
    a_valid = 1'b0; a_ack = 4'b0000;
    tick();
    chk_a("t3b.g2", 4'b0100, 1'b1, 1'b0);
    a_ack = 4'b0100;
    tick();
    chk_a("t3b.done2", 4'b0000, 1'b1, 1'b1);
    chk_a_done("t3b.done2", 2'd2, 2'b00);
    a_ack = 4'b0000;

    // 5: idx 2, foreign ack bit 1 ignored, ack 2 on the timeout cycle wins
    a_enc = 2'd2; a_valid = 1'b1;
    tick();
    chk_a("t5.c1", 4'b0100, 1'b1, 1'b0);
    a_valid = 1'b0; a_ack = 4'b0010;
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk_a($sformatf("t5.c%0d", k), 4'b0100, 1'b1, 1'b0);
    end
    a_ack = 4'b0110;
    tick();
    chk_a("t5.done", 4'b0000, 1'b1, 1'b1);
    chk_a_done("t5.done", 2'd2, 2'b00);
    a_ack = 4'b0000;
    tick();

    // 6: async reset mid-grant with a pending request
    a_enc = 2'd1; a_valid = 1'b1;
    tick();
    chk_a("t6.g1", 4'b0010, 1'b1, 1'b0);
    a_enc = 2'd2;
    tick();
    chk_a("t6.pend", 4'b0010, 1'b0, 1'b0);
    a_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_a("t6.async", 4'b0000, 1'b1, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_a("t6.rel1", 4'b0000, 1'b1, 1'b0);
    tick();
    chk_a("t6.rel2", 4'b0000, 1'b1, 1'b0);
    a_enc = 2'd3; a_valid = 1'b1;
    tick();
    chk_a("t6.recover", 4'b1000, 1'b1, 1'b0);
    a_valid = 1'b0;

    // 4: WIDTH=5, out-of-range idx 6
    b_enc = 3'd6; b_valid = 1'b1;
    tick();
    chk_b("t4.range", 5'b00000, 1'b1, 1'b1, 3'd6, 2'b10);
    b_valid = 1'b0;
    tick();
    chk_b("t4.after", 5'b00000, 1'b1, 1'b0, 3'd6, 2'b10);

    // Top index 4 with timeout disabled: grant holds until ack
    b_enc = 3'd4; b_valid = 1'b1;
    tick();
    chk_b("t4b.g4", 5'b10000, 1'b1, 1'b0, 3'd6, 2'b10);
    b_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
    end
    chk_b("t4b.hold", 5'b10000, 1'b1, 1'b0, 3'd6, 2'b10);
    b_ack = 5'b10000;
    tick();
    chk_b("t4b.done", 5'b00000, 1'b1, 1'b1, 3'd4, 2'b00);
    b_ack = 5'b00000;

    // Out-of-range pending: ack pulse, then range pulse one cycle later
    b_enc = 3'd1; b_valid = 1'b1;
    tick();
    chk_b("t4c.g1", 5'b00010, 1'b1, 1'b0, 3'd4, 2'b00);
    b_enc = 3'd7;
    tick();
    chk_b("t4c.pend", 5'b00010, 1'b0, 1'b0, 3'd4, 2'b00);
    b_valid = 1'b0; b_ack = 5'b00010;
    tick();
    chk_b("t4c.ack", 5'b00000, 1'b0, 1'b1, 3'd1, 2'b00);
    b_ack = 5'b00000;
    tick();
    chk_b("t4c.range", 5'b00000, 1'b1, 1'b1, 3'd7, 2'b10);
    tick();
    chk_b("t4c.idle", 5'b00000, 1'b1, 1'b0, 3'd7, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/onehot_grant_decoder.md
Name: onehot_grant_decoder

Overview:
- Sequential counterpart of the priority encoder: accepts a binary-encoded index on a valid/ready stream and drives the matching one-hot grant line.
- Holds the grant until the selected target acknowledges or a timeout expires, then reports completion.
- Has a one-deep pending buffer, so the next request can be taken while a grant is active.
- Sits between an arbiter or encoder front end and WIDTH target agents.

Parameters:
WIDTH, 4, number of grant lines, >= 2, need not be a power of two
TIMEOUT, 255, cycles a grant may stay active without ack; 0 disables the timeout
IW, $clog2(WIDTH), derived index width; not overridden by instantiators

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
input_encoded  input  IW  requested grant index
input_valid  input  1  request valid
input_ready  output  1  request accepted when input_valid && input_ready
output_unencoded  output  WIDTH  one-hot grant, all-zero when idle
output_valid  output  1  grant active (equals |output_unencoded)
output_ack  input  WIDTH  per-target acknowledge; only the bit of the active index is honoured
done_valid  output  1  single-cycle completion pulse
done_encoded  output  IW  index that completed
done_status  output  2  completion status: 00 ack, 01 timeout, 10 out-of-range index

Behaviour:
Reset (rst_n low, asynchronous): the following are all cleared.
- State goes to IDLE.
- output_unencoded=0, output_valid=0.
- done_valid=0, done_encoded=0, done_status=0.
- Pending buffer empty; timeout counter=0.
- input_ready=1 once rst_n deasserts. Reset mid-grant drops the grant immediately, with no done pulse.

State machine:
- Two states: IDLE and ACTIVE.
- One pending register: pend_valid and pend_idx.
- input_ready = !pend_valid, registered-equivalent, with no combinational path from input_valid.

IDLE:
- On acceptance with index < WIDTH: next cycle ACTIVE, output_unencoded = 1<<index, counter=0. Latency is 1 cycle from the acceptance edge to the grant.
- On acceptance with index >= WIDTH: stay IDLE. Next cycle done_valid=1, done_status=10, done_encoded=index. No grant is driven.

ACTIVE:
- The counter increments each cycle.
- If output_ack[active_idx]=1 at edge M: at M+1 done_valid=1, status 00, done_encoded=active_idx, and the grant is removed.
- Else if TIMEOUT!=0 and counter==TIMEOUT-1 at edge M: same as ack, but status 01. The grant is therefore high for exactly TIMEOUT cycles.
- Ack and timeout in the same cycle: ack wins.
- Ack bits other than the active index are ignored.
- An acceptance while ACTIVE loads the pending register.

Completion with a pending request:
- At M+1 the pending index is granted directly, with no idle bubble; the done pulse occurs in the same cycle. Counter=0, pending cleared, input_ready=1 at M+1.
- An out-of-range pending index produces its own status-10 done pulse one cycle after the completion pulse.

Completion with no pending request:
- Return to IDLE at M+1.
- A request accepted in the same cycle as completion goes to the pending register, then follows the rule above.

Invariants:
- output_unencoded is always zero or one-hot.
- At most one done pulse per cycle.
- done_* is valid only while done_valid=1 and holds its last value otherwise.
- The counter saturates and never wraps; it needs $clog2(TIMEOUT+1) bits, minimum 1.

Decomposition:
- Shared package holds the done_status encodings (ST_ACK=2'b00, ST_TIMEOUT=2'b01, ST_RANGE=2'b10) and the IDLE/ACTIVE state constants.
- One natural sub-module: grant_timeout_counter, a clear/enable saturating counter with a terminal-count flag, also reusable by other timeout logic.
- Index-to-one-hot conversion is a single shift inline; no sub-module.

Test Plan:
1. Reset, then request idx 2 with WIDTH=4 and ack at the 3rd grant cycle -> output_unencoded=4'b0100 for 3 cycles, then done_valid pulse with done_encoded=2, status 00, input_ready stays 1.
2. Request idx 1, never ack, TIMEOUT=8 -> grant 4'b0010 high exactly 8 cycles, then done status 01, done_encoded=1.
3. Request idx 0, then idx 3 while active, ack idx 0 -> next cycle grant 4'b1000 with done(0,00) in the same cycle; input_ready low during pending, high again after.
4. WIDTH=5, request idx 6 -> no grant; next cycle done status 10, done_encoded=6.
5. Idx 2 active, ack on bit 1 only, then ack bit 2 and timeout terminal in the same cycle -> bit 1 ignored; completion with status 00.
6. Assert rst_n low mid-grant with a pending request -> outputs zero asynchronously, no done pulse, pending discarded, input_ready=1 after release.
